bcd_counter: RTL
================

Name: bcd_counter

Overview:
- Synchronous multi-digit BCD up/down counter; the upstream stage that produces the 4-bit BCD digits (W = bit 3 MSB, X, Y, Z = bit 0 LSB) consumed by the team's BCD-to-seven-segment decoders.
- Each digit nibble wires directly to one decoder instance.
- Supports parallel load, count enable, direction select, a carry/borrow output for cascading, and a flag for illegal (non-BCD) loads.

Parameters:
- DIGITS, 2, number of BCD decades; counter width is 4*DIGITS bits; legal range 1..8.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clk when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  value to load; digit i is bits [4i+3:4i].
- q  output  4*DIGITS  registered count; digit i is bits [4i+3:4i], bit 4i+3 = W, bit 4i = Z.
- co  output  1  combinational carry/borrow out, for cascading.
- load_err  output  1  registered one-cycle pulse after an illegal load.

Behaviour:
- Reset: asynchronous and active-low, as already decided. rst_n low forces q = 0 and load_err = 0 immediately. co = 0 while in reset.
- Priority per clock: load > en > hold.
- Load: q <= load_val on the next edge, with one exception: any nibble > 9 is written as 0 instead.
  - load_err <= 1 for exactly one cycle if any nibble was > 9; otherwise load_err <= 0.
  - en is ignored in a load cycle; co = 0 in a load cycle.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and increments the next digit.
  - Ripple is resolved within one cycle. Latency: q updates on the edge after en is sampled.
- Count down (en=1, up=0):
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and decrements the next digit.
- Terminal count:
  - Up at all-9s (e.g. 99) wraps to all-0s; co = 1 during that cycle.
  - Down at all-0s wraps to all-9s; co = 1 during that cycle.
  - co = en & ~load & terminal(direction); otherwise co = 0.
- q is always legal BCD (every nibble 0..9) at every clock; no reachable illegal state.
- Direction change mid-count takes effect on the very next enabled edge; no pipeline to flush.
- Reset asserted mid-count: state is lost immediately. First count after release starts from 0.
- load_err clears to 0 on any non-load cycle.

Optional Feature:
- Macro: BCD_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up at all-9s holds all-9s; down at all-0s holds all-0s.
  - co still asserts (as a "limit reached" indication) under the same condition.
- Undefined: wrap-around as above.

Decomposition:
- Package bcd_pkg holds:
  - localparam BCD_W = 4
  - localparam BCD_MAX = 4'd9
  - typedef logic [3:0] bcd_t
  - function is_bcd(bcd_t) returning 1 when the value is <= 9.
- One sub-module is natural: bcd_digit.
  - A single decade cell with inputs ci, up, cur and outputs nxt, co.
  - Instantiated DIGITS times in a generate loop, ci chained from the previous cell's co.
  - Digit 0 ci = en.
- Top level adds load muxing, sanitisation, load_err and the saturation logic.

Test Plan (DIGITS=2):
- Reset/start: rst_n=0 then 1, en=1, up=1 for 12 cycles -> q steps 00,01,...,09,10,11,12; co=0 throughout.
- Up-wrap: load 8'h98, en=1, up=1 -> q = 99, then 00; co=1 only in the cycle q=99 with en high; with BCD_COUNTER_SAT_EN, q holds 99.
- Down-wrap: load 8'h01, en=1, up=0 -> q = 00, then 99; co=1 in the cycle q=00; with BCD_COUNTER_SAT_EN, q holds 00.
- Illegal load: load_val=8'h3C -> q=30, load_err=1 for one cycle. Then load_val=8'h45 -> q=45, load_err=0.
- Priority: load=1, en=1, load_val=8'h27 at q=50 -> q=27 (no count applied), co=0. Flip up mid-run at q=27 -> next q=26.
- Async reset: assert rst_n low between clock edges at q=63 -> q=00 immediately, without waiting for clk.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the counter and its decade cells.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic logic is_bcd(input bcd_t v);
    return (v <= BCD_MAX);
  endfunction

  // Replaces any illegal nibble with zero so a load can never create a non-BCD state.
  function automatic bcd_t sanitize(input bcd_t v);
    return is_bcd(v) ? v : '0;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade cell: steps one BCD digit up or down when ci is high and
// reports a carry/borrow to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic ci,
  input  logic up,
  input  bcd_t cur,
  output bcd_t nxt,
  output logic co
);

  // NOTE: defaults assigned first so every path drives nxt and co; no latches.
  always_comb begin
    nxt = cur;
    co  = 1'b0;
    if (ci) begin
      if (up) begin
        // >= rather than == lets a corrupted nibble recover to 0 on the next step.
        if (cur >= BCD_MAX) begin
          nxt = '0;
          co  = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == '0) begin
          nxt = BCD_MAX;
          co  = 1'b1;
        end else if (cur > BCD_MAX) begin
          nxt = BCD_MAX;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade BCD up/down counter with parallel load, illegal-load flag and
// cascade carry/borrow. Define BCD_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                co,
  output logic                load_err
);

  localparam int W = BCD_W * DIGITS;

  logic [DIGITS:0] carry;
  logic [W-1:0]    cnt_nxt;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_clean;
  logic            load_bad;
  logic            terminal;

  // Ripple chain: digit 0 is stepped by en, each later digit by its neighbour's carry.
  assign carry[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .ci  (carry[i]),
      .up  (up),
      .cur (q[BCD_W*i +: BCD_W]),
      .nxt (cnt_nxt[BCD_W*i +: BCD_W]),
      .co  (carry[i+1])
    );
  end

  // Carry out of the top decade means every digit was at its limit in this direction.
  assign terminal = carry[DIGITS];

`ifdef BCD_COUNTER_SAT_EN
  assign step_val = terminal ? q : cnt_nxt;
`else
  assign step_val = cnt_nxt;
`endif

  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean[BCD_W*i +: BCD_W] = sanitize(load_val[BCD_W*i +: BCD_W]);
      if (!is_bcd(load_val[BCD_W*i +: BCD_W])) load_bad = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= load_clean;
      load_err <= load_bad;
    end else begin
      load_err <= 1'b0;
      if (en) q <= step_val;
    end
  end

  assign co = rst_n & ~load & terminal;

endmodule
